pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/execute sequencer driving PC select, ALU function and register write strobes
module pc_sequencer #(
  parameter int RETIRE_W = 8
) (
  input  logic                clk_main,
  input  logic                reset,
  input  logic                run,
  input  logic [15:0]         instr_in,
  input  logic                mem_ack,
  input  logic                zero_flag,
  input  logic                neg_flag,
  output logic                mem_req,
  output logic [1:0]          ps,
  output logic [3:0]          da,
  output logic [3:0]          sa,
  output logic [3:0]          sb,
  output logic [2:0]          fs,
  output logic                rf_we,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_NOP  = 3'd0,
    K_ALU  = 3'd1,
    K_BRZ  = 3'd2,
    K_BRN  = 3'd3,
    K_JMP  = 3'd4,
    K_HALT = 3'd5
  } kind_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  state_t      state;
  state_t      state_next;
  kind_t       kind;
  logic [15:0] ir;

  // Reserved opcodes 8, C, D, E fall through to NOP.
  always_comb begin
    kind = K_NOP;
    case (ir[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: kind = K_ALU;
      4'h9:    kind = K_BRZ;
      4'hA:    kind = K_BRN;
      4'hB:    kind = K_JMP;
      4'hF:    kind = K_HALT;
      default: kind = K_NOP;
    endcase
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      ir <= 16'h0000;
    end else if (state == S_FETCH && mem_ack) begin
      ir <= instr_in;
    end
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (state == S_EXECUTE && kind != K_HALT) begin
      retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (run) state_next = S_FETCH;
      S_FETCH:   if (mem_ack) state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: state_next = (kind == K_HALT) ? S_HALT : S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_IDLE;
    endcase
  end

  // Flags are looked at only here, so their value during DECODE never matters.
  always_comb begin
    ps    = PS_HOLD;
    rf_we = 1'b0;
    fs    = 3'b000;
    if (state == S_EXECUTE) begin
      case (kind)
        K_ALU: begin
          ps    = PS_INC;
          rf_we = 1'b1;
          fs    = ir[14:12];
        end
        K_BRZ:   ps = zero_flag ? PS_REL : PS_INC;
        K_BRN:   ps = neg_flag ? PS_REL : PS_INC;
        K_JMP:   ps = PS_JMP;
        K_HALT:  ps = PS_HOLD;
        default: ps = PS_INC;
      endcase
    end
  end

  assign mem_req = (state == S_FETCH);
  assign halted  = (state == S_HALT);
  assign da      = ir[11:8];
  assign sa      = ir[7:4];
  assign sb      = ir[3:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer against an instruction-level model
module tb_pc_sequencer;

  logic        clk_main = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr_in;
  logic        mem_ack;
  logic        zero_flag;
  logic        neg_flag;
  logic        mem_req;
  logic [1:0]  ps;
  logic [3:0]  da, sa, sb;
  logic [2:0]  fs;
  logic        rf_we;
  logic        halted;
  logic [7:0]  retired;

  int checks = 0;
  int errors = 0;

  int          obs_mreq;
  logic        obs_act;
  logic        obs_ir_moved;
  logic [1:0]  obs_ps;
  logic        obs_rf_we;
  logic [2:0]  obs_fs;
  logic [11:0] obs_regs;
  logic        obs_mreq_ex;

  pc_sequencer #(.RETIRE_W(8)) dut (
    .clk_main (clk_main),
    .reset    (reset),
    .run      (run),
    .instr_in (instr_in),
    .mem_ack  (mem_ack),
    .zero_flag(zero_flag),
    .neg_flag (neg_flag),
    .mem_req  (mem_req),
    .ps       (ps),
    .da       (da),
    .sa       (sa),
    .sb       (sb),
    .fs       (fs),
    .rf_we    (rf_we),
    .halted   (halted),
    .retired  (retired)
  );

  always #5 clk_main = ~clk_main;

  // Instruction-level expectation: {ps, rf_we, fs} in the execute cycle.
  function automatic logic [5:0] model_exec(input logic [15:0] instr, input logic zf, input logic nf);
    logic [3:0] op;
    op = instr[15:12];
    if (op >= 4'h1 && op <= 4'h7) return {2'b01, 1'b1, op[2:0]};
    if (op == 4'h9) return {(zf ? 2'b10 : 2'b01), 4'b0000};
    if (op == 4'hA) return {(nf ? 2'b10 : 2'b01), 4'b0000};
    if (op == 4'hB) return 6'b11_0_000;
    if (op == 4'hF) return 6'b00_0_000;
    return 6'b01_0_000;
  endfunction

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; instr_in = 16'h0;
    zero_flag = 1'b0; neg_flag = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic start();
    run = 1'b1;
    step();
  endtask

  // Entered one tick after the edge that put the DUT in FETCH; leaves it one tick after the execute edge.
  task automatic exec_instr(input logic [15:0] instr, input int stall,
                            input logic zf_dec, input logic nf_dec,
                            input logic zf_ex, input logic nf_ex);
    logic [11:0] regs0;
    obs_mreq = 0; obs_act = 1'b0; obs_ir_moved = 1'b0;
    regs0 = {da, sa, sb};
    for (int i = 0; i < stall; i++) begin
      mem_ack = 1'b0; instr_in = 16'($urandom);
      @(negedge clk_main);
      if (mem_req) obs_mreq++;
      if (ps != 2'b00 || rf_we || fs != 3'b000) obs_act = 1'b1;
      if ({da, sa, sb} !== regs0) obs_ir_moved = 1'b1;
      step();
    end
    mem_ack = 1'b1; instr_in = instr;
    @(negedge clk_main);
    if (mem_req) obs_mreq++;
    if (ps != 2'b00 || rf_we || fs != 3'b000) obs_act = 1'b1;
    if ({da, sa, sb} !== regs0) obs_ir_moved = 1'b1;
    step();
    mem_ack = 1'($urandom); instr_in = 16'($urandom);
    zero_flag = zf_dec; neg_flag = nf_dec;
    @(negedge clk_main);
    if (mem_req) obs_mreq++;
    if (ps != 2'b00 || rf_we || fs != 3'b000) obs_act = 1'b1;
    step();
    mem_ack = 1'($urandom); instr_in = 16'($urandom);
    zero_flag = zf_ex; neg_flag = nf_ex;
    @(negedge clk_main);
    obs_ps = ps; obs_rf_we = rf_we; obs_fs = fs;
    obs_regs = {da, sa, sb}; obs_mreq_ex = mem_req;
    step();
    mem_ack = 1'b0;
    zero_flag = 1'($urandom); neg_flag = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; instr_in = 16'h0;
    zero_flag = 1'b0; neg_flag = 1'b0;
    #1;
    checks++;
    if ({mem_req, ps, rf_we, fs, da, sa, sb, halted, retired} !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got mreq=%0b ps=%0d we=%0b fs=%0d regs=%03h halted=%0b ret=%0d want all zero",
               mem_req, ps, rf_we, fs, {da, sa, sb}, halted, retired);
    end
    do_reset();
    repeat (3) step();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_without_run: mem_req=%0b want 0", mem_req); end
  endtask

  task automatic test_alu_basic();
    do_reset();
    start();
    exec_instr(16'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_mreq !== 1) begin errors++; $display("FAIL alu_mreq_cycles: got %0d want 1", obs_mreq); end
    checks++;
    if ({obs_ps, obs_rf_we, obs_fs} !== 6'b01_1_001) begin
      errors++; $display("FAIL alu_exec: got ps=%0d we=%0b fs=%0d want ps=1 we=1 fs=1", obs_ps, obs_rf_we, obs_fs);
    end
    checks++;
    if (obs_regs !== 12'h234) begin errors++; $display("FAIL alu_regs: got %03h want 234", obs_regs); end
    checks++;
    if (obs_act !== 1'b0) begin errors++; $display("FAIL alu_early_strobe: got %0b want 0", obs_act); end
    checks++;
    if (retired !== 8'd1) begin errors++; $display("FAIL alu_retired: got %0d want 1", retired); end
  endtask

  task automatic test_stall();
    do_reset();
    start();
    exec_instr(16'h5ABC, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_mreq !== 6) begin errors++; $display("FAIL stall_mreq_cycles: got %0d want 6", obs_mreq); end
    checks++;
    if (obs_ir_moved !== 1'b0) begin errors++; $display("FAIL stall_ir_moved: got %0b want 0", obs_ir_moved); end
    checks++;
    if (obs_act !== 1'b0) begin errors++; $display("FAIL stall_strobe: got %0b want 0", obs_act); end
    checks++;
    if ({obs_ps, obs_rf_we, obs_fs, obs_regs} !== {6'b01_1_101, 12'hABC}) begin
      errors++; $display("FAIL stall_exec: got ps=%0d we=%0b fs=%0d regs=%03h want 1 1 5 abc",
                         obs_ps, obs_rf_we, obs_fs, obs_regs);
    end
  endtask

  task automatic test_branch();
    logic [5:0] pat [4];
    do_reset();
    start();
    // {zf_dec, zf_ex} and {nf_dec, nf_ex} pairs: decode-cycle value must not leak into execute.
    pat[0] = 6'b01_0000; pat[1] = 6'b00_0000; pat[2] = 6'b10_0000; pat[3] = 6'b11_0000;
    for (int i = 0; i < 4; i++) begin
      exec_instr(16'h9035, 0, pat[i][5], 1'b0, pat[i][4], 1'b0);
      checks++;
      if (obs_ps !== (pat[i][4] ? 2'b10 : 2'b01) || obs_rf_we !== 1'b0) begin
        errors++; $display("FAIL brz_%0d: got ps=%0d we=%0b want ps=%0d we=0", i, obs_ps, obs_rf_we,
                           pat[i][4] ? 2 : 1);
      end
      exec_instr(16'hA135, 0, 1'b0, pat[i][5], 1'b1, pat[i][4]);
      checks++;
      if (obs_ps !== (pat[i][4] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL brn_%0d: got ps=%0d want %0d", i, obs_ps, pat[i][4] ? 2 : 1);
      end
    end
  endtask

  task automatic test_random();
    int model_ret;
    logic [15:0] instr;
    logic [5:0]  exp;
    logic zd, nd, ze, ne;
    int stall;
    do_reset();
    start();
    model_ret = 0;
    for (int i = 0; i < 60; i++) begin
      instr = 16'($urandom);
      instr[15:12] = 4'($urandom_range(0, 14));
      stall = $urandom_range(0, 3);
      zd = 1'($urandom); nd = 1'($urandom); ze = 1'($urandom); ne = 1'($urandom);
      exec_instr(instr, stall, zd, nd, ze, ne);
      model_ret = model_ret + 1;
      exp = model_exec(instr, ze, ne);
      checks++;
      if ({obs_ps, obs_rf_we, obs_fs} !== exp) begin
        errors++; $display("FAIL rand_exec[%0d] instr=%04h: got %06b want %06b", i, instr,
                           {obs_ps, obs_rf_we, obs_fs}, exp);
      end
      checks++;
      if (obs_regs !== instr[11:0] || obs_ir_moved !== 1'b0) begin
        errors++; $display("FAIL rand_regs[%0d]: got %03h moved=%0b want %03h", i, obs_regs, obs_ir_moved, instr[11:0]);
      end
      checks++;
      if (obs_mreq !== stall + 1 || obs_mreq_ex !== 1'b0 || obs_act !== 1'b0) begin
        errors++; $display("FAIL rand_fetch[%0d]: got mreq=%0d ex=%0b act=%0b want %0d 0 0",
                           i, obs_mreq, obs_mreq_ex, obs_act, stall + 1);
      end
      checks++;
      if (retired !== 8'(model_ret % 256)) begin
        errors++; $display("FAIL rand_retired[%0d]: got %0d want %0d", i, retired, model_ret % 256);
      end
    end
  endtask

  task automatic test_nop_wrap();
    logic [15:0] instr;
    do_reset();
    start();
    for (int i = 0; i < 256; i++) begin
      instr = (i % 3 == 0) ? 16'hC000 : {4'h0, 12'($urandom)};
      exec_instr(instr, 0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
      if (i % 3 == 0) begin
        checks++;
        if ({obs_ps, obs_rf_we, obs_fs} !== 6'b01_0_000) begin
          errors++; $display("FAIL reserved_as_nop[%0d]: got %06b want 010000", i, {obs_ps, obs_rf_we, obs_fs});
        end
      end
      if (i == 254) begin
        checks++;
        if (retired !== 8'd255) begin errors++; $display("FAIL nop_255: got %0d want 255", retired); end
      end
    end
    checks++;
    if (retired !== 8'd0) begin errors++; $display("FAIL nop_wrap: got %0d want 0", retired); end
  endtask

  task automatic test_jmp_halt();
    do_reset();
    start();
    exec_instr(16'hB000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_ps !== 2'b11 || obs_rf_we !== 1'b0) begin
      errors++; $display("FAIL jmp_exec: got ps=%0d we=%0b want 3 0", obs_ps, obs_rf_we);
    end
    exec_instr(16'hF000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_ps !== 2'b00 || obs_rf_we !== 1'b0) begin
      errors++; $display("FAIL halt_exec: got ps=%0d we=%0b want 0 0", obs_ps, obs_rf_we);
    end
    for (int i = 0; i < 6; i++) begin
      run = 1'(i % 2); mem_ack = 1'b1;
      @(negedge clk_main);
      checks++;
      if ({halted, mem_req, ps, rf_we} !== 5'b1_0_00_0 || retired !== 8'd1) begin
        errors++; $display("FAIL halt_hold[%0d]: got halted=%0b mreq=%0b ps=%0d we=%0b ret=%0d want 1 0 0 0 1",
                           i, halted, mem_req, ps, rf_we, retired);
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    start();
    exec_instr(16'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; instr_in = 16'hABCD;
    #2;
    checks++;
    if (mem_req !== 1'b1 || da !== 4'h2) begin
      errors++; $display("FAIL pre_reset_fetch: got mreq=%0b da=%0h want 1 2", mem_req, da);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, ps, rf_we, fs, da, sa, sb, halted, retired} !== 29'h0) begin
      errors++; $display("FAIL async_reset_fetch: got mreq=%0b regs=%03h ret=%0d want 0 000 0",
                         mem_req, {da, sa, sb}, retired);
    end
    step();
    reset = 1'b1; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_main);
      checks++;
      if (mem_req !== 1'b0 || {da, sa, sb} !== 12'h000) begin
        errors++; $display("FAIL post_reset_idle[%0d]: got mreq=%0b regs=%03h want 0 000", i, mem_req, {da, sa, sb});
      end
      step();
    end
    run = 1'b1;
    step();
    mem_ack = 1'b1; instr_in = 16'h3456;
    step();
    mem_ack = 1'b0;
    step();
    #1;
    checks++;
    if (rf_we !== 1'b1 || fs !== 3'd3) begin
      errors++; $display("FAIL pre_reset_exec: got we=%0b fs=%0d want 1 3", rf_we, fs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, ps, rf_we, fs, da, sa, sb, halted, retired} !== 29'h0) begin
      errors++; $display("FAIL async_reset_exec: got ps=%0d we=%0b fs=%0d regs=%03h ret=%0d want all zero",
                         ps, rf_we, fs, {da, sa, sb}, retired);
    end
    step();
    checks++;
    if (retired !== 8'd0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_held: got ret=%0d mreq=%0b want 0 0", retired, mem_req);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_stall();
    test_branch();
    test_random();
    test_nop_wrap();
    test_jmp_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
